sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-requester round-robin arbiter in front of an SDRAM
// controller slave (Avalon-MM style).
//   clk_clk / reset_reset_n : clock, async active-low reset
//   mN_*                    : requester N command in, waitrequest and
//                             read return out (N = 0, 1)
//   s_*                     : command out to the controller, waitrequest and
//                             in-order read return in
//   err                     : sticky, set by a read return with no tag pending
// A tag FIFO records which requester owns each outstanding read so that the
// in-order returns can be routed back with one registered cycle of latency.
module sdram_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err
);
  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = $clog2(MAX_PEND + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t              r_state;
  logic                r_rr;
  logic [MAX_PEND-1:0] r_tag;
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [CW-1:0]       r_count;

  logic w_full, w_elig0, w_elig1, w_g0, w_g1, w_gelig, w_acc;
  logic w_rd0, w_rd1, w_push, w_pop;

  // write wins when both strobes are set
  assign w_rd0   = m0_read & ~m0_write;
  assign w_rd1   = m1_read & ~m1_write;
  assign w_full  = (r_count == CW'(MAX_PEND));
  assign w_elig0 = m0_write | (m0_read & ~w_full);
  assign w_elig1 = m1_write | (m1_read & ~w_full);
  assign w_g0    = (r_state == GNT0);
  assign w_g1    = (r_state == GNT1);
  // a grant only drives the slave while its command is still eligible
  assign w_gelig = reset_reset_n & ((w_g0 & w_elig0) | (w_g1 & w_elig1));
  assign w_acc   = w_gelig & ~s_waitrequest;
  assign w_push  = w_acc & (w_g1 ? w_rd1 : w_rd0);
  assign w_pop   = s_readdatavalid & (r_count != '0);

  always_comb begin
    s_address      = w_g1 ? m1_address    : m0_address;
    s_writedata    = w_g1 ? m1_writedata  : m0_writedata;
    s_byteenable   = w_g1 ? m1_byteenable : m0_byteenable;
    s_read         = w_gelig & (w_g1 ? w_rd1 : w_rd0);
    s_write        = w_gelig & (w_g1 ? m1_write : m0_write);
    m0_waitrequest = ~(w_acc & w_g0);
    m1_waitrequest = ~(w_acc & w_g1);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_elig0 && w_elig1) r_state <= r_rr ? GNT1 : GNT0;
          else if (w_elig0)       r_state <= GNT0;
          else if (w_elig1)       r_state <= GNT1;
        end
        GNT0: begin
          if (!w_elig0) r_state <= IDLE;
          else if (!s_waitrequest) begin
            r_rr    <= 1'b1;
            r_state <= w_elig1 ? GNT1 : GNT0;
          end
        end
        GNT1: begin
          if (!w_elig1) r_state <= IDLE;
          else if (!s_waitrequest) begin
            r_rr    <= 1'b0;
            r_state <= w_elig0 ? GNT0 : GNT1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // tag FIFO and registered read return
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tag            <= '0;
      r_wptr           <= '0;
      r_rptr           <= '0;
      r_count          <= '0;
      err              <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      if (w_push) begin
        r_tag[r_wptr] <= w_g1;
        r_wptr        <= (r_wptr == PW'(MAX_PEND-1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(MAX_PEND-1)) ? '0 : r_rptr + PW'(1);
        if (r_tag[r_rptr]) begin
          m1_readdata      <= s_readdata;
          m1_readdatavalid <= 1'b1;
        end else begin
          m0_readdata      <= s_readdata;
          m0_readdatavalid <= 1'b1;
        end
      end
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      // stray return: data dropped, flag held until reset
      if (s_readdatavalid && r_count == '0) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  localparam int AW = 24, DW = 16, MP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] m0_addr, m1_addr, s_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_wd, m1_wd, s_writedata, s_rd, m0_rdata, m1_rdata;
  logic [1:0]    m0_be, m1_be, s_byteenable;
  logic          m0_wait, m1_wait, m0_rdv, m1_rdv;
  logic          s_read, s_write, s_wait, s_rdv, err;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .m0_address(m0_addr), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_wd), .m0_byteenable(m0_be), .m0_waitrequest(m0_wait),
    .m0_readdata(m0_rdata), .m0_readdatavalid(m0_rdv),
    .m1_address(m1_addr), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_wd), .m1_byteenable(m1_be), .m1_waitrequest(m1_wait),
    .m1_readdata(m1_rdata), .m1_readdatavalid(m1_rdv),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_wait), .s_readdata(s_rd), .s_readdatavalid(s_rdv),
    .err(err)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [DW-1:0] data; int due; } ret_t;
  ret_t expq[$];   // expected read returns (scoreboard)
  int   tagq[$];   // model of outstanding read owners

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // drive one return this cycle; the model decides who should receive it
  task automatic ret(input logic [DW-1:0] d);
    ret_t e;
    s_rdv = 1'b1; s_rd = d;
    if (tagq.size() > 0) begin
      e.id = tagq.pop_front(); e.data = d; e.due = cyc + 1;
      expq.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    s_wait = 1'b0; s_rdv = 1'b0; s_rd = '0;
    tick();
    rst_n = 1'b1;
    tagq.delete();
  endtask

  // return monitor: checks routing, data and 1-cycle latency
  ret_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        mon_e = expq.pop_front();
        chk("rdv_target", (mon_e.id == 0) ? m0_rdv : m1_rdv, 1);
        chk("rdv_other",  (mon_e.id == 0) ? m1_rdv : m0_rdv, 0);
        chk("rdata", (mon_e.id == 0) ? m0_rdata : m1_rdata, mon_e.data);
      end else begin
        chk("no_rdv0", m0_rdv, 0);
        chk("no_rdv1", m1_rdv, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0; m0_be = '0; m1_be = '0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    s_wait = 1'b1; s_rdv = 1'b0; s_rd = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_m0_wait", m0_wait, 1);
    chk("rst_m1_wait", m1_wait, 1);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_err", err, 0);
    chk("rst_rdv", {m0_rdv, m1_rdv}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single write from m0, slave stalls two grant cycles
    m0_addr = 24'h000010; m0_wd = 16'h1234; m0_be = 2'b11; m0_write = 1; s_wait = 1;
    #1 chk("wr_idle_s_write", s_write, 0); chk("wr_idle_wait", m0_wait, 1);
    tick();
    #1 chk("wr_g1_s_write", s_write, 1); chk("wr_addr", s_address, 24'h10);
    chk("wr_data", s_writedata, 16'h1234); chk("wr_be", s_byteenable, 2'b11);
    chk("wr_g1_wait", m0_wait, 1); chk("wr_m1_wait", m1_wait, 1);
    tick();
    #1 chk("wr_g2_s_write", s_write, 1); chk("wr_g2_wait", m0_wait, 1);
    tick();
    s_wait = 0;
    #1 chk("wr_acc_wait", m0_wait, 0); chk("wr_acc_s_write", s_write, 1);
    tick();
    m0_write = 0;
    #1 chk("wr_post_wait", m0_wait, 1); chk("wr_post_s_write", s_write, 0);
    tick();
    #1 chk("wr_no_tag", dut.r_count, 0);

    // both masters reading continuously: strict alternation
    do_reset();
    m0_addr = 24'h000100; m1_addr = 24'h000200; m0_read = 1; m1_read = 1; s_wait = 0;
    #1 chk("rr_idle_s_read", s_read, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_m0_wait", m0_wait, (k % 2 == 0) ? 0 : 1);
      chk("rr_m1_wait", m1_wait, (k % 2 == 1) ? 0 : 1);
      chk("rr_s_read", s_read, 1);
      chk("rr_addr", s_address, (k % 2 == 0) ? 24'h100 : 24'h200);
      tagq.push_back(k % 2);
      tick();
    end
    m0_read = 0; m1_read = 0;
    #1 chk("rr_stop_s_read", s_read, 0);
    tick();
    for (int k = 0; k < 4; k++) begin ret(16'hA000 + 16'(k)); tick(); end
    s_rdv = 0; tick(); tick();
    #1 chk("rr_count0", dut.r_count, 0);

    // m1 fills all tags, 9th read is held until one return
    do_reset();
    m1_addr = 24'h000300; m1_read = 1; s_wait = 0;
    #1 tick();
    for (int k = 0; k < 8; k++) begin
      #1 chk("full_acc_wait", m1_wait, 0); chk("full_acc_s_read", s_read, 1);
      tagq.push_back(1);
      tick();
    end
    #1 chk("full_count8", dut.r_count, 8); chk("full_blk_s_read", s_read, 0);
    chk("full_blk_wait", m1_wait, 1);
    tick();
    #1 chk("full_idle_s_read", s_read, 0); chk("full_idle_wait", m1_wait, 1);
    tick();
    #1 chk("full_hold_s_read", s_read, 0);
    ret(16'hB000);
    tick();
    s_rdv = 0;
    #1 chk("full_pop_s_read", s_read, 0);
    tick();
    #1 chk("full_9th_s_read", s_read, 1); chk("full_9th_wait", m1_wait, 0);
    chk("full_count7", dut.r_count, 7);
    tagq.push_back(1);
    tick();
    m1_read = 0;
    for (int k = 0; k < 8; k++) begin ret(16'hB100 + 16'(k)); tick(); end
    s_rdv = 0; tick(); tick();
    #1 chk("full_count0", dut.r_count, 0);

    // push+pop at count 3, then pointer wrap with interleaved returns
    do_reset();
    m0_addr = 24'h000400; m0_read = 1; s_wait = 0;
    #1 tick();
    for (int k = 0; k < 3; k++) begin
      #1 chk("pp_acc_wait", m0_wait, 0);
      tagq.push_back(0);
      tick();
    end
    m0_read = 0;
    #1 chk("pp_stop_s_read", s_read, 0);
    tick();
    #1 chk("pp_count3", dut.r_count, 3);
    m1_addr = 24'h000500; m1_read = 1;
    tick();
    #1 chk("pp_m1_acc", m1_wait, 0);
    ret(16'hC000);
    tagq.push_back(1);
    tick();
    m1_read = 0; s_rdv = 0;
    #1 chk("pp_count_same", dut.r_count, 3);
    tick(); tick();
    m0_read = 1; m1_read = 1;
    #1 tick();
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("wrap_m0_wait", m0_wait, (k % 2 == 0) ? 0 : 1);
      chk("wrap_m1_wait", m1_wait, (k % 2 == 1) ? 0 : 1);
      if (k % 3 != 0) ret(16'hD000 + 16'(k));
      else s_rdv = 0;
      tagq.push_back(k % 2);
      tick();
    end
    m0_read = 0; m1_read = 0; s_rdv = 0;
    #1 chk("wrap_count7", dut.r_count, 7);
    tick();
    for (int k = 0; k < 7; k++) begin ret(16'hD100 + 16'(k)); tick(); end
    s_rdv = 0; tick(); tick();
    #1 chk("wrap_count0", dut.r_count, 0);

    // stray return with nothing outstanding
    do_reset();
    #1 chk("stray_err_pre", err, 0);
    ret(16'hEEEE);
    tick();
    s_rdv = 0;
    #1 chk("stray_err_set", err, 1);
    tick(); tick();
    #1 chk("stray_err_sticky", err, 1);

    // reset with 4 reads pending
    do_reset();
    m0_addr = 24'h000600; m0_read = 1; s_wait = 0;
    #1 tick();
    for (int k = 0; k < 5; k++) begin
      #1 chk("rp_acc_wait", m0_wait, 0);
      tagq.push_back(0);
      tick();
    end
    m0_read = 0;
    ret(16'hF0F0);
    tick();
    s_rdv = 0;
    tick();
    #1 chk("rp_count4", dut.r_count, 4); chk("rp_rdata_pre", m0_rdata, 16'hF0F0);
    m0_read = 1;
    tick();
    #1 chk("rp_gnt_s_read", s_read, 1);
    rst_n = 0;
    #1;
    chk("rp_s_read", s_read, 0); chk("rp_s_write", s_write, 0);
    chk("rp_m0_wait", m0_wait, 1); chk("rp_m1_wait", m1_wait, 1);
    chk("rp_rdata", {m0_rdata, m1_rdata}, 0); chk("rp_rdv", {m0_rdv, m1_rdv}, 0);
    chk("rp_err", err, 0); chk("rp_count", dut.r_count, 0);
    m0_read = 0;
    tagq.delete();
    tick();
    rst_n = 1;
    tick();
    ret(16'h1111);
    tick();
    s_rdv = 0;
    #1 chk("rp_stray_err", err, 1);
    tick();

    chk("scoreboard_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
